// File: rtl/seven_seg_scan_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment display stage.
// Segment codes are active-low in {g,f,e,d,c,b,a} order.
package seven_seg_scan_pkg;

  localparam int IDX_W = 2;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF   = 4'b1111;

endpackage

// File: rtl/seven_seg_scan_bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-BCD codes show a dash so a corrupted digit is visible but never all-on.
module bcd_to_seg
  import seven_seg_scan_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Map each BCD value to its segment pattern, anything else to a dash
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a common-anode 4-digit 7-segment display.
// Digits are snapshotted once per frame so a counter update never tears the image;
// each digit slot opens with a short all-anodes-off window to suppress ghosting.
module seven_seg_scan
  import seven_seg_scan_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV  = 16'd50000,
  parameter logic [15:0] BLANK_CYC = 16'd500,
  parameter logic [25:0] BLINK_DIV = 26'd25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_0,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic [3:0] digit_3,
  input  logic [3:0] blink_sel,
  input  logic [3:0] dp_mask,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  logic [15:0]      r_scanCnt;
  logic [IDX_W-1:0] r_idx;
  logic [25:0]      r_blinkCnt;
  logic             r_blinkOn;
  logic [3:0]       r_shDigit [0:3];
  logic [3:0]       r_shBlink;
  logic [3:0]       r_shDp;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;

  logic             w_scanWrap;
  logic             w_blinkWrap;
  logic             w_frameEnd;
  logic [3:0]       w_curDigit;
  logic [6:0]       w_segDecoded;
  logic [6:0]       w_segNext;
  logic             w_dpNext;
  logic [3:0]       w_anNext;

  assign w_scanWrap  = (r_scanCnt == SCAN_DIV - 16'd1);
  assign w_blinkWrap = (r_blinkCnt == BLINK_DIV - 26'd1);
  assign w_frameEnd  = w_scanWrap && (r_idx == IDX_W'(3));
  assign w_curDigit  = r_shDigit[r_idx];

  bcd_to_seg u_bcdToSeg (
    .i_bcd (w_curDigit),
    .o_seg (w_segDecoded)
  );

  // Slot timer and digit index; the index advances only when a slot expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scanCnt <= 16'd0;
      r_idx     <= '0;
    end else if (w_scanWrap) begin
      r_scanCnt <= 16'd0;
      r_idx     <= r_idx + IDX_W'(1);
    end else begin
      r_scanCnt <= r_scanCnt + 16'd1;
    end
  end

  // Free-running blink phase, starts in the visible half after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blinkCnt <= 26'd0;
      r_blinkOn  <= 1'b1;
    end else if (w_blinkWrap) begin
      r_blinkCnt <= 26'd0;
      r_blinkOn  <= ~r_blinkOn;
    end else begin
      r_blinkCnt <= r_blinkCnt + 26'd1;
    end
  end

  // Capture the displayed values only at the frame boundary to keep frames coherent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shDigit[0] <= 4'd0;
      r_shDigit[1] <= 4'd0;
      r_shDigit[2] <= 4'd0;
      r_shDigit[3] <= 4'd0;
      r_shBlink    <= 4'd0;
      r_shDp       <= 4'd0;
    end else if (w_frameEnd) begin
      r_shDigit[0] <= digit_0;
      r_shDigit[1] <= digit_1;
      r_shDigit[2] <= digit_2;
      r_shDigit[3] <= digit_3;
      r_shBlink    <= blink_sel;
      r_shDp       <= dp_mask;
    end
  end

  // Derive next pin values: blank window first, then the selected digit unless blinked off
  always_comb begin
    w_anNext  = AN_OFF;
    w_segNext = SEG_OFF;
    w_dpNext  = 1'b1;
    if (r_scanCnt >= BLANK_CYC) begin
      w_segNext = w_segDecoded;
      w_dpNext  = ~r_shDp[r_idx];
      if (!(r_shBlink[r_idx] && !r_blinkOn)) begin
        w_anNext = ~(4'b0001 << r_idx);
      end
    end
  end

  // Register the pins so the display sees glitch-free levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_OFF;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_anNext;
      r_seg <= w_segNext;
      r_dp  <= w_dpNext;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan with SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=8.
// The stimulus process pushes the expected {an,seg,dp} for every clock edge; a monitor
// pops and compares on the following falling edge.
module tb_seven_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] digit_0, digit_1, digit_2, digit_3;
  logic [3:0] blink_sel, dp_mask;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  logic [11:0] expQ [$];
  int          tagQ [$];
  int          nChecks = 0;
  int          nFails  = 0;
  int          k;
  logic [3:0]  shD [0:3];
  logic [3:0]  shBlink, shDp;

  seven_seg_scan #(
    .SCAN_DIV  (16'd4),
    .BLANK_CYC (16'd1),
    .BLINK_DIV (26'd8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digit_0   (digit_0),
    .digit_1   (digit_1),
    .digit_2   (digit_2),
    .digit_3   (digit_3),
    .blink_sel (blink_sel),
    .dp_mask   (dp_mask),
    .seg       (seg),
    .dp        (dp),
    .an        (an)
  );

  always #5 clk = ~clk;

  // Hand-written decode table: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10, else 3F
  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Pins after edge kk show the state left by edge kk-1: slot = 4 cycles, frame = 16,
  // blink half-period = 8 cycles starting visible
  function automatic logic [11:0] expected(input int kk);
    int j, sc, ix;
    logic on;
    logic [3:0] anE;
    j  = kk - 1;
    sc = j % 4;
    ix = (j / 4) % 4;
    on = ((j / 8) % 2) == 0;
    if (sc < 1) return {4'b1111, 7'h7F, 1'b1};
    anE = (shBlink[ix] && !on) ? 4'b1111 : (4'b1111 ^ (4'b0001 << ix));
    return {anE, segOf(shD[ix]), ~shDp[ix]};
  endfunction

  task automatic pushReset();
    expQ.push_back({4'b1111, 7'h7F, 1'b1});
    tagQ.push_back(-1);
  endtask

  task automatic clearShadow();
    for (int i = 0; i < 4; i++) shD[i] = 4'd0;
    shBlink = 4'd0;
    shDp    = 4'd0;
  endtask

  // Directed input changes keyed on the edge count since reset release
  task automatic driveSchedule(input int kk);
    case (kk)
      25: digit_0 = 4'd8;
      36: begin digit_2 = 4'hC; dp_mask = 4'b0100; end
      52: blink_sel = 4'b1111;
      68: blink_sel = 4'b0001;
      84: begin blink_sel = 4'b0000; dp_mask = 4'b0000; end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input int nCycles);
    for (int c = 0; c < nCycles; c++) begin
      @(posedge clk);
      k++;
      #1;
      expQ.push_back(expected(k));
      tagQ.push_back(k);
      if (k % 16 == 0) begin
        shD[0]  = digit_0;
        shD[1]  = digit_1;
        shD[2]  = digit_2;
        shD[3]  = digit_3;
        shBlink = blink_sel;
        shDp    = dp_mask;
      end
      driveSchedule(k);
    end
  endtask

  task automatic checkOutput(input logic [11:0] exp, input int tag);
    nChecks++;
    if ({an, seg, dp} !== exp) begin
      nFails++;
      $display("[TB] FAIL edge %0d an/seg/dp: got %b/%h/%b expected %b/%h/%b",
               tag, an, seg, dp, exp[11:8], exp[7:1], exp[0]);
    end
  endtask

  // Monitor: one expectation is consumed per falling edge
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front(), tagQ.pop_front());
    end
  end

  initial begin
    #20000;
    nFails++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    digit_3 = 4'd5; digit_2 = 4'd9; digit_1 = 4'd0; digit_0 = 4'd7;
    blink_sel = 4'b0000; dp_mask = 4'b0000;
    k = 0;
    clearShadow();
    #2 rst_n = 1'b0;
    $display("[TB] holding reset");
    repeat (3) begin
      @(posedge clk);
      #1;
      pushReset();
    end
    rst_n = 1'b1;

    // Frame 0 shows zeros; frame 1 shows 1110/78, 1101/40, 1011/10, 0111/12;
    // digit_0 changes at idx 2 of frame 1, visible from frame 2; dash+dp on digit 2 in
    // frame 3; all-digit blink in frame 4; digit 0 blink in frame 5
    $display("[TB] scanning");
    applyStimulus(105);

    // Async reset while idx=2, scan_cnt=2: pins must drop before the next clock edge
    @(posedge clk);
    k++;
    #2 rst_n = 1'b0;
    pushReset();
    $display("[TB] mid-slot reset at edge %0d", k);
    repeat (2) begin
      @(posedge clk);
      #1;
      pushReset();
    end
    rst_n = 1'b1;
    k = 0;
    clearShadow();
    applyStimulus(20);

    repeat (3) @(negedge clk);
    if (expQ.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
